// File: rtl/mem_delay_arbiter_if.sv
// Requester-side bundle: one request channel plus one response channel.
// The master modport is the requester (IFU/LSU); the slave modport is the arbiter.
interface mem_delay_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic            req_wen;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_delay_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// One transaction in flight; each one is stretched by a fixed or LFSR-drawn
// delay before the single-cycle memory strobe, to emulate variable latency.
module mem_delay_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DLY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_delay_arbiter_if.slave m0,
    mem_delay_arbiter_if.slave m1,
    input  logic               cfg_fixed,
    input  logic [DLY_W-1:0]   cfg_delay,
    output logic               mem_en,
    output logic               mem_wen,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic [DW/8-1:0]    mem_wmask,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int                MW  = DW / 8;
    localparam logic [DLY_W-1:0]  ONE = {{(DLY_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [DLY_W-1:0] r_lfsr, r_cnt, r_dly;
    logic             r_prio;     // 0: m0 wins a tie, 1: m1 wins a tie
    logic             r_id;       // requester owning the in-flight transaction
    logic             r_wen;
    logic             r_hold;     // response data has been captured
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata, r_rdata;
    logic [MW-1:0]    r_wmask;

    logic             w_gnt, w_idle, w_req_hs, w_rsp_ready, w_rsp_hs;
    logic [DLY_W-1:0] w_dly;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_wdata, w_rdata;
    logic [MW-1:0]    w_wmask;
    logic             w_wen;

    // Grant selection: lone valid requester wins, a tie goes to the priority holder
    always_comb begin
        w_gnt = 1'b0;
        if (m0.req_valid && m1.req_valid) w_gnt = r_prio;
        else if (m1.req_valid)            w_gnt = 1'b1;
    end

    assign w_idle       = (r_state == S_IDLE);
    assign m0.req_ready = w_idle && m0.req_valid && !w_gnt;
    assign m1.req_ready = w_idle && m1.req_valid &&  w_gnt;
    assign w_req_hs     = w_idle && (m0.req_valid || m1.req_valid);

    assign w_addr  = w_gnt ? m1.req_addr  : m0.req_addr;
    assign w_wen   = w_gnt ? m1.req_wen   : m0.req_wen;
    assign w_wdata = w_gnt ? m1.req_wdata : m0.req_wdata;
    assign w_wmask = w_gnt ? m1.req_wmask : m0.req_wmask;
    assign w_dly   = cfg_fixed ? cfg_delay : r_lfsr;

    assign w_rsp_ready = r_id ? m1.rsp_ready : m0.rsp_ready;
    assign w_rsp_hs    = (r_state == S_RESP) && w_rsp_ready;

    // Memory data shows up the cycle after the strobe, i.e. the first RESP
    // cycle; pass it straight through then and replay the captured copy after.
    always_comb begin
        w_rdata = r_rdata;
        if (r_state == S_RESP && !r_hold) w_rdata = r_wen ? '0 : mem_rdata;
    end

    assign m0.rsp_valid = (r_state == S_RESP) && !r_id;
    assign m1.rsp_valid = (r_state == S_RESP) &&  r_id;
    assign m0.rsp_rdata = w_rdata;
    assign m1.rsp_rdata = w_rdata;

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;

    // Free-running delay source, independent of traffic
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= '1;
        else     r_lfsr <= {r_lfsr[DLY_W-2:0], r_lfsr[DLY_W-1] ^ r_lfsr[DLY_W-2]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and memory strobe
    always_comb begin
        w_next  = r_state;
        mem_en  = 1'b0;
        mem_wen = 1'b0;
        case (r_state)
            S_IDLE:   if (w_req_hs) w_next = (w_dly != '0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (r_cnt == r_dly - ONE) w_next = S_ACCESS;
            S_ACCESS: begin
                mem_en  = 1'b1;
                mem_wen = r_wen;
                w_next  = S_RESP;
            end
            S_RESP:   if (w_rsp_hs) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latches, delay counter, response capture and priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_wen   <= 1'b0;
            r_hold  <= 1'b0;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req_hs) begin
                    r_id    <= w_gnt;
                    r_addr  <= w_addr;
                    r_wen   <= w_wen;
                    r_wdata <= w_wdata;
                    r_wmask <= w_wmask;
                    r_dly   <= w_dly;
                    r_cnt   <= '0;
                end
                S_WAIT: r_cnt <= r_cnt + ONE;
                S_RESP: begin
                    if (!r_hold) begin
                        r_rdata <= w_rdata;
                        r_hold  <= 1'b1;
                    end
                    if (w_rsp_hs) begin
                        r_hold <= 1'b0;
                        r_prio <= ~r_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_delay_arbiter.sv
// Directed bench for mem_delay_arbiter: latency, payload, round-robin order,
// response back-pressure, LFSR-drawn delays and mid-transaction reset.
module tb_mem_delay_arbiter;
    localparam int AW = 32, DW = 32, DLY_W = 4;

    logic             clk, rst;
    logic             cfg_fixed;
    logic [DLY_W-1:0] cfg_delay;
    logic             mem_en, mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;
    logic [DW/8-1:0]  mem_wmask;

    mem_delay_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_delay_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    mem_delay_arbiter #(.AW(AW), .DW(DW), .DLY_W(DLY_W)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
        .cfg_fixed(cfg_fixed), .cfg_delay(cfg_delay),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid only the cycle after a read strobe,
    // garbage otherwise so that unheld response data is exposed.
    int n_mem_en = 0;
    always @(posedge clk) begin
        if (mem_en) n_mem_en <= n_mem_en + 1;
        if (mem_en && !mem_wen)
            mem_rdata <= (mem_addr == 32'h8000_0000) ? 32'hDEAD_BEEF : (mem_addr ^ 32'h5A5A_0000);
        else
            mem_rdata <= $urandom;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input bit id, input logic [AW-1:0] a, input bit w,
                       input logic [DW-1:0] d, input logic [3:0] m);
        if (!id) begin
            m0_if.req_valid = 1'b1; m0_if.req_addr = a; m0_if.req_wen = w;
            m0_if.req_wdata = d; m0_if.req_wmask = m;
        end else begin
            m1_if.req_valid = 1'b1; m1_if.req_addr = a; m1_if.req_wen = w;
            m1_if.req_wdata = d; m1_if.req_wmask = m;
        end
        #1;
        chk(id ? "m1_req_ready" : "m0_req_ready", id ? m1_if.req_ready : m0_if.req_ready, 1'b1);
    endtask

    // Cycles from the request handshake cycle to the mem_en cycle; -1 on timeout.
    task automatic wait_mem_en(output int n);
        int k;
        k = 0; n = -1;
        while (n < 0 && k < 40) begin
            tick(); k++;
            if (mem_en) n = k;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctl"}, {mem_en, mem_wen, m0_if.rsp_valid, m1_if.rsp_valid,
                            m0_if.req_ready, m1_if.req_ready}, 6'b0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_wmask"}, mem_wmask, 0);
        chk({tag, "_rdata"}, m0_if.rsp_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, ok_v, ok_d, ok_r, ok_e, mem_before;
        rst = 1'b1; cfg_fixed = 1'b1; cfg_delay = '0;
        m0_if.req_valid = 0; m0_if.req_addr = 0; m0_if.req_wen = 0; m0_if.req_wdata = 0; m0_if.req_wmask = 0;
        m1_if.req_valid = 0; m1_if.req_addr = 0; m1_if.req_wen = 0; m1_if.req_wdata = 0; m1_if.req_wmask = 0;
        m0_if.rsp_ready = 1'b1; m1_if.rsp_ready = 1'b1;
        tick(); tick(); tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // m0 read, D=0: mem_en at T+1, response at T+2
        req(0, 32'h8000_0000, 0, 0, 4'hF);
        wait_mem_en(n);
        m0_if.req_valid = 0;
        chk("t1_lat", n, 1);
        chk("t1_wen", mem_wen, 0);
        chk("t1_addr", mem_addr, 32'h8000_0000);
        tick();
        chk("t1_rsp_valid", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b10);
        chk("t1_rdata", m0_if.rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // m1 write, D=5; config change after acceptance must not matter
        cfg_delay = 4'd5;
        req(1, 32'h8000_0010, 1, 32'h1234_5678, 4'hF);
        chk("t2_m0_ready", m0_if.req_ready, 0);
        tick(); m1_if.req_valid = 0; cfg_delay = 4'd1;
        wait_mem_en(n);
        chk("t2_lat", n + 1, 6);
        chk("t2_wen", mem_wen, 1);
        chk("t2_addr", mem_addr, 32'h8000_0010);
        chk("t2_wdata", mem_wdata, 32'h1234_5678);
        chk("t2_wmask", mem_wmask, 4'hF);
        tick();
        chk("t2_rsp_valid", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b01);
        chk("t2_rdata", m1_if.rsp_rdata, 0);
        tick();

        // Both requesting continuously, D=0: m0,m1,m0,m1 every 3 cycles
        cfg_delay = 4'd0;
        m0_if.req_valid = 1; m0_if.req_addr = 32'h100; m0_if.req_wen = 0;
        m1_if.req_valid = 1; m1_if.req_addr = 32'h200; m1_if.req_wen = 0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m0_if.req_ready || m1_if.req_ready) begin
                chk("rr_cycle", c, 3 * k);
                chk("rr_id", {m0_if.req_ready, m1_if.req_ready}, (k % 2) ? 2'b01 : 2'b10);
                k++;
            end
            tick();
        end
        m0_if.req_valid = 0; m1_if.req_valid = 0;
        chk("rr_count", k, 4);
        tick();

        // Response back-pressure on m0 while m1 keeps requesting (pointer back at m0)
        m0_if.rsp_ready = 0;
        m1_if.req_valid = 1; m1_if.req_addr = 32'h200;
        req(0, 32'h8000_0000, 0, 0, 4'hF);
        chk("bp_m1_ready", m1_if.req_ready, 0);
        tick(); m0_if.req_valid = 0;
        tick();
        ok_v = 0; ok_d = 0; ok_r = 0; ok_e = 0;
        for (int i = 0; i < 10; i++) begin
            if (m0_if.rsp_valid) ok_v++;
            if (m0_if.rsp_rdata == 32'hDEAD_BEEF) ok_d++;
            #1;
            if (!m1_if.req_ready) ok_r++;
            if (!mem_en) ok_e++;
            tick();
        end
        chk("bp_valid_held", ok_v, 10);
        chk("bp_rdata_held", ok_d, 10);
        chk("bp_m1_blocked", ok_r, 10);
        chk("bp_no_mem_en", ok_e, 10);
        m0_if.rsp_ready = 1;
        #1;
        chk("bp_m1_ready_resp", m1_if.req_ready, 0);
        tick();
        #1;
        chk("bp_m1_accept", m1_if.req_ready, 1);
        tick(); m1_if.req_valid = 0;
        tick();
        chk("bp_m1_rsp_valid", m1_if.rsp_valid, 1);
        chk("bp_m1_rdata", m1_if.rsp_rdata, 32'h5A5A_0200);
        tick();

        // LFSR delays: 1111 at index 0, 1000 at index 18, 0111 at index 29
        rst = 1; cfg_fixed = 0;
        tick(); tick();
        rst = 0;
        req(0, 32'h8000_0000, 0, 0, 4'hF);
        wait_mem_en(n);
        m0_if.req_valid = 0;
        chk("lfsr_d15_lat", n, 16);
        tick();
        chk("lfsr_rdata", m0_if.rsp_rdata, 32'hDEAD_BEEF);
        tick();
        req(1, 32'h300, 0, 0, 4'hF);
        wait_mem_en(n);
        m1_if.req_valid = 0;
        chk("lfsr_d8_lat", n, 9);
        tick(); tick();
        req(0, 32'h400, 0, 0, 4'hF);
        wait_mem_en(n);
        m0_if.req_valid = 0;
        chk("lfsr_d7_lat", n, 8);
        tick(); tick();

        // Reset 4 cycles into WAIT (pointer currently at m1)
        cfg_fixed = 1; cfg_delay = 4'd10;
        req(1, 32'h8000_0020, 1, 32'hCAFE_F00D, 4'h3);
        mem_before = n_mem_en;
        tick(); m1_if.req_valid = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        check_zero_outputs("wrst");
        rst = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("wrst_no_mem_en", n_mem_en, mem_before);
        m0_if.req_valid = 1; m0_if.req_addr = 32'h500; m0_if.req_wen = 0;
        m1_if.req_valid = 1; m1_if.req_addr = 32'h600; m1_if.req_wen = 0;
        #1;
        chk("wrst_grant", {m0_if.req_ready, m1_if.req_ready}, 2'b10);
        tick(); m0_if.req_valid = 0; m1_if.req_valid = 0;
        for (int i = 0; i < 12; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
